// File: rtl/mem_cmd_decoder.sv
// DDR4-style command/address decoder: registered command/power pulses, CKE power-state tracking,
// open-bank and MPR tracking, protocol-violation flagging. Define MEM_CMD_DECODER_DPD_EN for deep power-down.
module mem_cmd_decoder #(
    parameter int BG_WIDTH   = 2,
    parameter int BA_WIDTH   = 2,
    parameter int ADDR_WIDTH = 17,
    parameter int COL_WIDTH  = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cke,
    input  logic                                  cs_n,
    input  logic                                  act_n,
    input  logic [BG_WIDTH-1:0]                   bg,
    input  logic [BA_WIDTH-1:0]                   ba,
    input  logic [ADDR_WIDTH-1:0]                 addr,
    output logic                                  ACT,
    output logic                                  RD,
    output logic                                  RDA,
    output logic                                  WR,
    output logic                                  WRA,
    output logic                                  PR,
    output logic                                  PRA,
    output logic                                  REF,
    output logic                                  MRW,
    output logic                                  MRR,
    output logic                                  CFG,
    output logic                                  BST,
    output logic                                  PD,
    output logic                                  PDX,
    output logic                                  SRF,
    output logic                                  CKEL,
    output logic                                  CKEH,
    output logic                                  DPD,
    output logic                                  DPDX,
    output logic [BG_WIDTH+BA_WIDTH-1:0]          bank_id,
    output logic [ADDR_WIDTH-1:0]                 row,
    output logic [COL_WIDTH-1:0]                  col,
    output logic [2**(BG_WIDTH+BA_WIDTH)-1:0]     open_banks,
    output logic                                  mpr_mode,
    output logic                                  err,
    output logic [7:0]                            err_cnt
);

    localparam int BANK_W    = BG_WIDTH + BA_WIDTH;
    localparam int NUM_BANKS = 2**BANK_W;

    typedef enum logic [1:0] {P_ON, P_PD, P_SR, P_DPD} pwr_t;

    // {A16,A15,A14} when act_n=1
    typedef enum logic [2:0] {
        E_MRW = 3'b000, E_REF = 3'b001, E_PR  = 3'b010, E_BST = 3'b011,
        E_WR  = 3'b100, E_RD  = 3'b101, E_CFG = 3'b110, E_NOP = 3'b111
    } enc_t;

    typedef struct packed {
        logic act, rd, rda, wr, wra, pr, pra, refresh, mrw, mrr, cfg, bst;
        logic pd, pdx, srf, ckel, ckeh, dpd, dpdx;
    } pulse_t;

    pwr_t                  pwr_q, pwr_d;
    logic                  cke_q;
    pulse_t                pulse_q, pulse_d;
    logic [BANK_W-1:0]     bank_id_d;
    logic [ADDR_WIDTH-1:0] row_d;
    logic [COL_WIDTH-1:0]  col_d;
    logic [NUM_BANKS-1:0]  open_d;
    logic                  mpr_d;
    logic                  err_d;

    logic                  fall, rise, cmd_valid, a10, is_nop, is_ref;
    logic [BANK_W-1:0]     bank_sel;
    enc_t                  enc;

    assign fall      = cke_q & ~cke;
    assign rise      = ~cke_q & cke;
    assign cmd_valid = cke_q & cke & ~cs_n & (pwr_q == P_ON);
    assign enc       = enc_t'(addr[ADDR_WIDTH-1 -: 3]);
    assign a10       = addr[10];
    assign bank_sel  = {bg, ba};
    assign is_nop    = cs_n | (act_n & (enc == E_NOP));
    assign is_ref    = ~cs_n & act_n & (enc == E_REF);

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        pwr_d     = pwr_q;
        pulse_d   = '0;
        bank_id_d = bank_id;
        row_d     = row;
        col_d     = col;
        open_d    = open_banks;
        mpr_d     = mpr_mode;
        err_d     = 1'b0;

        pulse_d.ckel = fall;
        pulse_d.ckeh = rise;

        if (fall && pwr_q == P_ON) begin
            // The command sampled with the falling CKE is never executed; only its encoding matters.
            if (is_ref && open_banks == '0) begin
                pulse_d.srf = 1'b1;
                pwr_d       = P_SR;
            end
`ifdef MEM_CMD_DECODER_DPD_EN
            else if (!cs_n && act_n && enc == E_CFG) begin
                pulse_d.dpd = 1'b1;
                pwr_d       = P_DPD;
            end
`endif
            else begin
                pulse_d.pd = 1'b1;
                pwr_d      = P_PD;
                err_d      = ~is_nop;
            end
        end else if (rise) begin
            case (pwr_q)
                P_PD:  pulse_d.pdx = 1'b1;
                P_DPD: begin
`ifdef MEM_CMD_DECODER_DPD_EN
                    pulse_d.dpdx = 1'b1;
                    open_d       = '0;
                    mpr_d        = 1'b0;
`endif
                end
                default: ;
            endcase
            pwr_d = P_ON;
        end else if (cmd_valid) begin
            if (!act_n) begin
                pulse_d.act       = 1'b1;
                err_d             = open_banks[bank_sel];
                open_d[bank_sel]  = 1'b1;
                bank_id_d         = bank_sel;
                row_d             = addr;
            end else begin
                case (enc)
                    E_MRW: begin
                        pulse_d.mrw = 1'b1;
                        if (bg == '0 && ba == BA_WIDTH'(3))
                            mpr_d = addr[2];
                    end
                    E_REF: begin
                        pulse_d.refresh = 1'b1;
                        err_d           = (open_banks != '0);
                    end
                    E_PR: begin
                        if (a10) begin
                            pulse_d.pra = 1'b1;
                            open_d      = '0;
                        end else begin
                            pulse_d.pr       = 1'b1;
                            open_d[bank_sel] = 1'b0;
                            bank_id_d        = bank_sel;
                        end
                    end
                    E_BST: pulse_d.bst = 1'b1;
                    E_CFG: pulse_d.cfg = 1'b1;
                    E_NOP: ;
                    E_WR, E_RD: begin
                        if (enc == E_RD && mpr_mode) begin
                            pulse_d.mrr = 1'b1;
                        end else begin
                            pulse_d.rd  = (enc == E_RD) & ~a10;
                            pulse_d.rda = (enc == E_RD) &  a10;
                            pulse_d.wr  = (enc == E_WR) & ~a10;
                            pulse_d.wra = (enc == E_WR) &  a10;
                            err_d       = ~open_banks[bank_sel];
                            bank_id_d   = bank_sel;
                            col_d       = addr[COL_WIDTH-1:0];
                            if (a10)
                                open_d[bank_sel] = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr_q      <= P_ON;
            cke_q      <= 1'b1;
            pulse_q    <= '0;
            bank_id    <= '0;
            row        <= '0;
            col        <= '0;
            open_banks <= '0;
            mpr_mode   <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            pwr_q      <= pwr_d;
            cke_q      <= cke;
            pulse_q    <= pulse_d;
            bank_id    <= bank_id_d;
            row        <= row_d;
            col        <= col_d;
            open_banks <= open_d;
            mpr_mode   <= mpr_d;
            err        <= err_d;
            if (err_d && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign ACT  = pulse_q.act;
    assign RD   = pulse_q.rd;
    assign RDA  = pulse_q.rda;
    assign WR   = pulse_q.wr;
    assign WRA  = pulse_q.wra;
    assign PR   = pulse_q.pr;
    assign PRA  = pulse_q.pra;
    assign REF  = pulse_q.refresh;
    assign MRW  = pulse_q.mrw;
    assign MRR  = pulse_q.mrr;
    assign CFG  = pulse_q.cfg;
    assign BST  = pulse_q.bst;
    assign PD   = pulse_q.pd;
    assign PDX  = pulse_q.pdx;
    assign SRF  = pulse_q.srf;
    assign CKEL = pulse_q.ckel;
    assign CKEH = pulse_q.ckeh;
    assign DPD  = pulse_q.dpd;
    assign DPDX = pulse_q.dpdx;

endmodule
